// File: rtl/cpu_pipe_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared definitions for the elastic pipeline stage registers of the
//   pipelined MIPS-Lite CPU.
//   - pipe_state_e : occupancy state of a skid-buffered stage register
//   - NOP_INSTR    : all-zero instruction; stages build their bubble payload
//                    from it at instantiation
// ----------------------------------------------------------------------------
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage : cpu_pipe_pkg

// File: rtl/pipe_skid_reg_if.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg_if
//   Valid/ready handshake bundle carrying a DATA_W-bit payload.
//   Ports (per modport):
//     master : drives valid, data; receives ready
//     slave  : receives valid, data; drives ready
// ----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface : pipe_skid_reg_if

// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
//   Elastic pipeline register with a 2-entry skid buffer. Replaces the
//   enable-gated stage registers so that stall back-pressure never needs a
//   combinational path from downstream ready to upstream ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_EMPTY | nothing held; out_valid=0, in_ready=1
//   ST_FULL  | head entry in r_main; out_valid=1, in_ready=1
//   ST_SKID  | head in r_main, next entry in r_skid; in_ready=0
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset (clears the stall counter)
//     flush      synchronous; drops all held entries and same-cycle input
//     up         slave side  : in_valid / in_ready / in_data
//     dn         master side : out_valid / out_ready / out_data
//     stall_cnt  saturating count of cycles with out_valid & !out_ready
// ----------------------------------------------------------------------------
module pipe_skid_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_skid_reg_if.slave      up,
    pipe_skid_reg_if.master     dn,
    output logic [CNT_W-1:0]    stall_cnt
);

    pipe_state_e       r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_accept;
    logic              w_consume;

    // Handshakes are qualified only by registered flags, so neither ready
    // nor valid ever depends combinationally on the opposite side.
    assign w_accept  = up.valid & r_in_ready;
    assign w_consume = r_out_valid & dn.ready;

    assign up.ready  = r_in_ready;
    assign dn.valid  = r_out_valid;
    // r_main is forced to BUBBLE_VAL whenever the stage empties, so the
    // output needs no mux.
    assign dn.data   = r_main;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main      <= BUBBLE_VAL;
            r_skid      <= BUBBLE_VAL;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // Stall accounting survives flush; only reset clears it.
            if (r_out_valid && !dn.ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end

            if (flush) begin
                r_state     <= ST_EMPTY;
                r_main      <= BUBBLE_VAL;
                r_skid      <= BUBBLE_VAL;
                r_in_ready  <= 1'b1;
                r_out_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_main      <= up.data;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_FULL;
                        end
                    end

                    ST_FULL: begin
                        if (w_accept && w_consume) begin
                            r_main <= up.data;
                        end else if (w_accept) begin
                            // Downstream stalled: park the extra entry.
                            r_skid     <= up.data;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_SKID;
                        end else if (w_consume) begin
                            r_main      <= BUBBLE_VAL;
                            r_out_valid <= 1'b0;
                            r_state     <= ST_EMPTY;
                        end
                    end

                    ST_SKID: begin
                        // in_ready is low here, so only a consume can happen.
                        if (w_consume) begin
                            r_main     <= r_skid;
                            r_skid     <= BUBBLE_VAL;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_FULL;
                        end
                    end

                    default: begin
                        r_state     <= ST_EMPTY;
                        r_main      <= BUBBLE_VAL;
                        r_skid      <= BUBBLE_VAL;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule : pipe_skid_reg

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;
    import cpu_pipe_pkg::*;

    localparam int                DATA_W = 64;
    localparam int                CNT_W  = 4;
    localparam logic [DATA_W-1:0] BUBBLE = {32'h0000_0000, NOP_INSTR};

    logic clk;
    logic rst;
    logic flush;
    logic [CNT_W-1:0] stall_cnt;

    pipe_skid_reg_if #(.DATA_W(DATA_W)) up_if ();
    pipe_skid_reg_if #(.DATA_W(DATA_W)) dn_if ();

    pipe_skid_reg #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                         input logic r, input logic f);
        up_if.valid = v;
        up_if.data  = d;
        dn_if.ready = r;
        flush       = f;
    endtask

    function automatic logic [DATA_W-1:0] pay(input int i);
        return {32'h0040_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i)};
    endfunction

    // Monitor: outputs are stable between the drive point (posedge+1) and
    // the next edge, so a consume is observed on the falling edge before it.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dn_if.valid === 1'b1 && dn_if.ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", dn_if.data, BUBBLE);
                    if (dn_if.data === BUBBLE) begin
                        n_pass--;
                        $display("FAIL unexpected_output: actual=consume with empty queue required=no consume");
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("out_order", dn_if.data, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] a, b, c;
        int base;
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready",  64'(up_if.ready), 64'd1);
        check("rst_out_valid", 64'(dn_if.valid), 64'd0);
        check("rst_out_data",  dn_if.data, BUBBLE);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);

        // Stream 01..05 with downstream always ready.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 64'(i), 1'b1, 1'b0);
            exp_q.push_back(64'(i));
            step();
            check("stream_latency", dn_if.data, 64'(i));
            check("stream_in_ready", 64'(up_if.ready), 64'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step();
        check("stream_drained", 64'(dn_if.valid), 64'd0);
        check("stream_stall", 64'(stall_cnt), 64'd0);

        // Back-pressure: A held, B into skid, C held upstream.
        a = pay(10); b = pay(11); c = pay(12);
        drive(1'b1, a, 1'b0, 1'b0); exp_q.push_back(a); step();
        drive(1'b1, b, 1'b0, 1'b0); exp_q.push_back(b); step();
        check("bp_in_ready_low", 64'(up_if.ready), 64'd0);
        drive(1'b1, c, 1'b0, 1'b0); step();
        check("bp_still_skid", 64'(up_if.ready), 64'd0);
        check("bp_head", dn_if.data, a);
        drive(1'b1, c, 1'b1, 1'b0); step();
        check("bp_recover", 64'(up_if.ready), 64'd1);
        check("bp_head_b", dn_if.data, b);
        exp_q.push_back(c); step();
        check("bp_head_c", dn_if.data, c);
        drive(1'b0, '0, 1'b1, 1'b0); step();
        check("bp_stall_cnt", 64'(stall_cnt), 64'd2);

        // Flush in SKID with D presented and A2 consumed in the flush cycle.
        a = pay(20); b = pay(21); c = pay(22);
        drive(1'b1, a, 1'b0, 1'b0); exp_q.push_back(a); step();
        drive(1'b1, b, 1'b0, 1'b0); step();
        check("fl_pre_skid", 64'(up_if.ready), 64'd0);
        drive(1'b1, c, 1'b1, 1'b1); step();
        check("fl_out_valid", 64'(dn_if.valid), 64'd0);
        check("fl_out_data", dn_if.data, BUBBLE);
        check("fl_in_ready", 64'(up_if.ready), 64'd1);
        check("fl_stall_kept", 64'(stall_cnt), 64'd3);
        drive(1'b0, '0, 1'b1, 1'b0); step();
        check("fl_d_dropped", 64'(dn_if.valid), 64'd0);

        // Accept and consume together for 10 cycles.
        drive(1'b1, pay(30), 1'b1, 1'b0); exp_q.push_back(pay(30)); step();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, pay(30 + i), 1'b1, 1'b0);
            exp_q.push_back(pay(30 + i));
            step();
            check("thru_valid", 64'(dn_if.valid), 64'd1);
            check("thru_in_ready", 64'(up_if.ready), 64'd1);
        end
        drive(1'b0, '0, 1'b1, 1'b0); step();
        check("thru_drained", 64'(dn_if.valid), 64'd0);
        check("thru_stall", 64'(stall_cnt), 64'd3);

        // Saturation: one entry held for 20 cycles with out_ready low.
        drive(1'b1, pay(50), 1'b0, 1'b0); step();
        base = 3;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            step();
            check("sat_cnt", 64'(stall_cnt), 64'((base + k > 15) ? 15 : base + k));
        end

        // Reset with flush and input while in SKID.
        drive(1'b1, pay(51), 1'b0, 1'b0); step();
        check("rs_pre_skid", 64'(up_if.ready), 64'd0);
        check("rs_pre_cnt", 64'(stall_cnt), 64'd15);
        drive(1'b1, pay(52), 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        check("rs_in_ready", 64'(up_if.ready), 64'd1);
        check("rs_out_valid", 64'(dn_if.valid), 64'd0);
        check("rs_out_data", dn_if.data, BUBBLE);
        check("rs_stall_cnt", 64'(stall_cnt), 64'd0);

        // Stage works normally after reset.
        drive(1'b1, pay(60), 1'b1, 1'b0); exp_q.push_back(pay(60)); step();
        check("post_rst_data", dn_if.data, pay(60));
        drive(1'b0, '0, 1'b1, 1'b0); step();
        step();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_skid_reg
